// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
// Serially loads NUM_PADS configuration words of CFG_BITS each into a
// daisy-chained pad-control chain. The last pad's word goes out first, MSB
// first within each word. A single serial_load strobe then latches the chain.
//
// Ports
//   clock        : single rising-edge clock
//   resetn       : asynchronous active-low reset
//   xfer         : start request, honoured only when idle and not busy
//   cfg_addr     : pad index whose configuration word is being read
//   cfg_rdata    : configuration word for cfg_addr (combinational read)
//   serial_clock : shift clock to the chain
//   serial_data  : shift data to the chain
//   serial_load  : one-cycle latch strobe after the last bit
//   busy         : transfer in progress
//   done         : one-cycle completion pulse, the cycle after serial_load
module gpio_serial_loader #(
   parameter int NUM_PADS = 38,
   parameter int CFG_BITS = 13,
   localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
   localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                xfer,
   output logic [AW-1:0]       cfg_addr,
   input  logic [CFG_BITS-1:0] cfg_rdata,
   output logic                serial_clock,
   output logic                serial_data,
   output logic                serial_load,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LOAD
   } state_t;

   localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] pad_idx_q, pad_idx_d;
   logic [BW-1:0] bit_idx_q, bit_idx_d;
   logic          serial_clock_q, serial_clock_d;
   logic          serial_data_q, serial_data_d;
   logic          serial_load_q, serial_load_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Next-state and registered-output logic.
   // busy follows "state was not IDLE last cycle", which keeps it high through
   // the serial_load cycle and low in the done cycle. Gating the start on
   // !busy_q is what stops a held xfer from restarting during serial_load.
   always_comb begin
      state_d        = state_q;
      pad_idx_d      = pad_idx_q;
      bit_idx_d      = bit_idx_q;
      serial_clock_d = serial_clock_q;
      serial_data_d  = serial_data_q;
      serial_load_d  = 1'b0;
      busy_d         = (state_q != IDLE);
      done_d         = serial_load_q;

      case (state_q)
         IDLE: begin
            if (xfer && !busy_q) begin
               state_d   = SHIFT_LO;
               pad_idx_d = LAST_PAD;
               bit_idx_d = LAST_BIT;
            end
         end
         SHIFT_LO: begin
            // Data is launched a full cycle ahead of the serial_clock rise.
            serial_data_d  = cfg_rdata[bit_idx_q];
            serial_clock_d = 1'b0;
            state_d        = SHIFT_HI;
         end
         SHIFT_HI: begin
            serial_clock_d = 1'b1;
            if (bit_idx_q != '0) begin
               bit_idx_d = bit_idx_q - BW'(1);
               state_d   = SHIFT_LO;
            end else if (pad_idx_q != '0) begin
               pad_idx_d = pad_idx_q - AW'(1);
               bit_idx_d = LAST_BIT;
               state_d   = SHIFT_LO;
            end else begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            serial_clock_d = 1'b0;
            serial_load_d  = 1'b1;
            state_d        = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= IDLE;
         pad_idx_q      <= '0;
         bit_idx_q      <= '0;
         serial_clock_q <= 1'b0;
         serial_data_q  <= 1'b0;
         serial_load_q  <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pad_idx_q      <= pad_idx_d;
         bit_idx_q      <= bit_idx_d;
         serial_clock_q <= serial_clock_d;
         serial_data_q  <= serial_data_d;
         serial_load_q  <= serial_load_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   // pad_idx always finishes a transfer at 0, so cfg_addr reads 0 when idle.
   assign cfg_addr     = pad_idx_q;
   assign serial_clock = serial_clock_q;
   assign serial_data  = serial_data_q;
   assign serial_load  = serial_load_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
